// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax datapath: data width, FP literals,
// and the state encoding used by the exponential-unit sharing arbiter.
package softmax_pkg;

    localparam int DATALENGTH = 32;

    localparam logic [DATALENGTH-1:0] FP_ONE  = 32'h3f80_0000;
    localparam logic [DATALENGTH-1:0] FP_HALF = 32'h3f00_0000;

    localparam int DEFAULT_TIMEOUT    = 255;
    localparam int DEFAULT_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/exp_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: searches from ptr_i+1 upward with wrap
// and returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/exp_share_arbiter.sv
// Shares one level-enabled exponential unit among NREQ softmax lanes: round-robin
// grant, Str held until Ack or watchdog expiry, one-cycle Done, then a forced Str-low gap.
module exp_share_arbiter
    import softmax_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = DATALENGTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ*DW-1:0] ReqData,
    output logic [NREQ-1:0]    Grant,
    output logic [NREQ-1:0]    Done,
    output logic               Error,
    output logic [DW-1:0]      Result,
    output logic               Busy,
    output logic               ExpStr,
    output logic [DW-1:0]      ExpDatain,
    input  logic               ExpAck,
    input  logic [DW-1:0]      ExpDataOut
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    arb_state_e state_q, state_d;

    logic [NREQ-1:0] grant_q,   grant_d;
    logic [NREQ-1:0] done_q,    done_d;
    logic            error_q,   error_d;
    logic [DW-1:0]   result_q,  result_d;
    logic            busy_q;
    logic            exp_str_q, exp_str_d;
    logic [DW-1:0]   exp_dat_q, exp_dat_d;
    logic [IW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IW-1:0]   owner_q,   owner_d;
    logic [CW-1:0]   run_cnt_q, run_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [DW-1:0]   lane_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_data[g] = ReqData[g*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req_i (Req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|Req) state_d = RUN;
            RUN:     if (ExpAck || run_cnt_q == RUN_LAST) state_d = DONE;
            DONE:    state_d = GAP;
            GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        done_d    = '0;
        error_d   = error_q;
        result_d  = result_q;
        exp_str_d = exp_str_q;
        exp_dat_d = exp_dat_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|Req) begin
                    grant_d   = arb_gnt;
                    owner_d   = arb_idx;
                    exp_dat_d = lane_data[arb_idx];
                    exp_str_d = 1'b1;
                    run_cnt_d = '0;
                end
            end
            RUN: begin
                exp_str_d = 1'b1;
                run_cnt_d = run_cnt_q + CW'(1);
                // Ack beats the watchdog when both land on the same edge
                if (ExpAck) begin
                    result_d  = ExpDataOut;
                    error_d   = 1'b0;
                    done_d    = grant_q;
                    exp_str_d = 1'b0;
                end else if (run_cnt_q == RUN_LAST) begin
                    result_d  = '0;
                    error_d   = 1'b1;
                    done_d    = grant_q;
                    exp_str_d = 1'b0;
                end
            end
            DONE: begin
                grant_d   = '0;
                error_d   = 1'b0;
                exp_str_d = 1'b0;
                rr_ptr_d  = owner_q;
                gap_cnt_d = '0;
            end
            GAP: begin
                exp_str_d = 1'b0;
                gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: begin
                exp_str_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            exp_str_q <= 1'b0;
            exp_dat_q <= '0;
            rr_ptr_q  <= IW'(NREQ - 1);
            owner_q   <= '0;
            run_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
            result_q  <= result_d;
            busy_q    <= (state_d != IDLE);
            exp_str_q <= exp_str_d;
            exp_dat_q <= exp_dat_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            run_cnt_q <= run_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign Grant     = grant_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign Result    = result_q;
    assign Busy      = busy_q;
    assign ExpStr    = exp_str_q;
    assign ExpDatain = exp_dat_q;

endmodule

// File: tb/tb_exp_share_arbiter.sv
// Bench for exp_share_arbiter: behavioural exp unit, job-level reference model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_exp_share_arbiter;

    localparam int NREQ       = 4;
    localparam int DW         = 32;
    localparam int TIMEOUT    = 16;
    localparam int GAP_CYCLES = 2;

    logic                Clock = 1'b0;
    logic                Reset;
    logic [NREQ-1:0]     Req;
    logic [NREQ*DW-1:0]  ReqData;
    logic [NREQ-1:0]     Grant;
    logic [NREQ-1:0]     Done;
    logic                Error;
    logic [DW-1:0]       Result;
    logic                Busy;
    logic                ExpStr;
    logic [DW-1:0]       ExpDatain;
    logic                ExpAck;
    logic [DW-1:0]       ExpDataOut;

    int n_chk  = 0;
    int n_fail = 0;

    exp_share_arbiter #(
        .NREQ       (NREQ),
        .DW         (DW),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .ReqData    (ReqData),
        .Grant      (Grant),
        .Done       (Done),
        .Error      (Error),
        .Result     (Result),
        .Busy       (Busy),
        .ExpStr     (ExpStr),
        .ExpDatain  (ExpDatain),
        .ExpAck     (ExpAck),
        .ExpDataOut (ExpDataOut)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] unit_fn(input logic [31:0] x);
        return (x == 32'h3f80_0000) ? 32'h402d_f854 : (x ^ 32'h1234_5678);
    endfunction

    // behavioural exponential unit: Ack after ack_lat+1 edges of Str high
    int ack_lat   = 5;
    bit ack_never = 1'b0;
    bit ack_pulse = 1'b0;
    int str_cnt   = 0;

    always @(posedge Clock) begin
        #1;
        if (ExpStr) str_cnt++;
        else        str_cnt = 0;
    end

    assign ExpAck     = ack_pulse || (!ack_never && ExpStr && (str_cnt == ack_lat + 1));
    assign ExpDataOut = unit_fn(ExpDatain);

    // job-level reference model
    int cyc     = 0;
    int m_last  = NREQ - 1;
    int m_g     = -100;
    int m_d     = -100;
    int m_next  = 0;
    int m_w     = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_res  = '0;
    bit   m_err  = 1'b0;
    int   lo_run = 0;
    bit   burst_seen = 1'b0;
    int   grant_log[$];

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        int c;
        for (int i = 1; i <= NREQ; i++) begin
            c = (last + i) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge Clock) begin
        int  ack_edge, to_edge;
        bit  in_run, at_done, busy_e;
        logic [NREQ-1:0] oh;
        #1;
        cyc++;
        if (!Reset) begin
            chk("rst_grant",  Grant,     0);
            chk("rst_done",   Done,      0);
            chk("rst_error",  Error,     0);
            chk("rst_result", Result,    0);
            chk("rst_str",    ExpStr,    0);
            chk("rst_datain", ExpDatain, 0);
            chk("rst_busy",   Busy,      0);
            m_last = NREQ - 1;
            m_g = -100;
            m_d = -100;
            m_next = cyc + 1;
            burst_seen = 1'b0;
            lo_run = 0;
        end else begin
            if (cyc >= m_next && Req != 0) begin
                m_w    = pick(Req, m_last);
                m_last = m_w;
                m_g    = cyc;
                m_data = ReqData[m_w*DW +: DW];
                ack_edge = ack_never ? (1 << 30) : cyc + ack_lat + 1;
                to_edge  = cyc + TIMEOUT;
                if (ack_edge <= to_edge) begin
                    m_d = ack_edge; m_err = 1'b0; m_res = unit_fn(m_data);
                end else begin
                    m_d = to_edge;  m_err = 1'b1; m_res = '0;
                end
                m_next = m_d + 2 + GAP_CYCLES;
                grant_log.push_back(m_w);
            end
            in_run  = (cyc >= m_g) && (cyc < m_d);
            at_done = (cyc == m_d);
            busy_e  = (cyc >= m_g) && (cyc <= m_d + GAP_CYCLES);
            oh = '0;
            oh[m_w] = 1'b1;
            chk("m_grant", Grant,  (in_run || at_done) ? oh : '0);
            chk("m_done",  Done,   at_done ? oh : '0);
            chk("m_str",   ExpStr, in_run);
            chk("m_busy",  Busy,   busy_e);
            chk("m_error", Error,  at_done ? m_err : 1'b0);
            if (in_run)  chk("m_datain", ExpDatain, m_data);
            if (at_done) chk("m_result", Result, m_res);
            if (ExpStr) begin
                if (lo_run > 0 && burst_seen) chk("str_gap_ok", (lo_run >= GAP_CYCLES + 1), 1);
                lo_run = 0;
                burst_seen = 1'b1;
            end else begin
                lo_run++;
            end
        end
    end

    task automatic wait_done(input string nm, input logic [31:0] exp_data,
                             output int cnt, output int hi);
        cnt = 0;
        hi  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            cnt++;
            if (ExpStr) begin
                hi++;
                chk({nm, "_datain"}, ExpDatain, exp_data);
            end
            if (Done != 0) return;
        end
        chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            chk({nm, "_no_extra_done"}, Done, 0);
            if (!Busy) return;
        end
        chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        int cnt, hi;
        Reset = 1'b0;
        Req = '0;
        ReqData = '0;
        repeat (3) @(negedge Clock);
        chk("init_busy", Busy, 0);
        chk("init_str", ExpStr, 0);

        // reset in the middle of a running job
        Reset = 1'b1;
        Req = 4'b0001;
        ReqData[0 +: 32] = 32'h4000_0000;
        repeat (3) @(negedge Clock);
        chk("pre_rst_str", ExpStr, 1);
        Reset = 1'b0;
        Req = '0;
        #1;
        chk("rst_mid_str", ExpStr, 0);
        chk("rst_mid_grant", Grant, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("post_rst_done", Done, 0);
            chk("post_rst_busy", Busy, 0);
        end

        // single job on lane 2
        ReqData[64 +: 32] = 32'h3f80_0000;
        Req = 4'b0100;
        wait_done("single", 32'h3f80_0000, cnt, hi);
        chk("single_lat", cnt, 7);
        chk("single_done", Done, 4'b0100);
        chk("single_res", Result, 32'h402d_f854);
        chk("single_err", Error, 0);
        Req = '0;
        @(negedge Clock);
        chk("single_pulse", Done, 0);
        wait_idle("single");

        // round robin from a fresh pointer
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) ReqData[i*DW +: DW] = 32'h3f00_0000 + 32'(i);
        Req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done("rr", 32'h3f00_0000 + 32'(rr_exp[j]), cnt, hi);
            chk("rr_done", Done, 4'b0001 << rr_exp[j]);
        end
        Req = '0;
        wait_idle("rr");
        chk("rr_count", grant_log.size(), 5);
        for (int j = 0; j < 5 && j < grant_log.size(); j++) chk("rr_order", grant_log[j], rr_exp[j]);

        // lane 1 just served, then 0 and 1 both request
        Req = 4'b0010;
        wait_done("prio_pre", 32'h3f00_0001, cnt, hi);
        chk("prio_pre_done", Done, 4'b0010);
        Req = '0;
        wait_idle("prio_pre");
        Req = 4'b0011;
        wait_done("prio_a", 32'h3f00_0000, cnt, hi);
        chk("prio_first", Done, 4'b0001);
        Req = 4'b0010;
        wait_done("prio_b", 32'h3f00_0001, cnt, hi);
        chk("prio_second", Done, 4'b0010);
        Req = '0;
        wait_idle("prio");

        // lane drops its request mid-job and still gets Done
        Req = 4'b1000;
        repeat (2) @(negedge Clock);
        Req = '0;
        wait_done("drop", 32'h3f00_0003, cnt, hi);
        chk("drop_done", Done, 4'b1000);
        wait_idle("drop");

        // stuck unit: watchdog
        ack_never = 1'b1;
        ReqData[96 +: 32] = 32'h4040_0000;
        Req = 4'b1000;
        wait_done("to", 32'h4040_0000, cnt, hi);
        chk("to_str_len", hi, 16);
        chk("to_lat", cnt, 17);
        chk("to_err", Error, 1);
        chk("to_res", Result, 0);
        chk("to_done", Done, 4'b1000);
        Req = '0;
        wait_idle("to");
        ack_never = 1'b0;
        ack_lat = 3;
        Req = 4'b1000;
        wait_done("after_to", 32'h4040_0000, cnt, hi);
        chk("after_to_lat", cnt, 5);
        chk("after_to_err", Error, 0);
        chk("after_to_res", Result, 32'h5274_5678);
        Req = '0;
        wait_idle("after_to");

        // Ack on the same edge as the watchdog: Ack wins
        ack_lat = TIMEOUT - 1;
        ReqData[64 +: 32] = 32'h3f80_0000;
        Req = 4'b0100;
        wait_done("bnd", 32'h3f80_0000, cnt, hi);
        chk("bnd_err", Error, 0);
        chk("bnd_res", Result, 32'h402d_f854);
        chk("bnd_str_len", hi, 16);
        Req = '0;
        wait_idle("bnd");
        // one edge later is too late
        ack_lat = TIMEOUT;
        Req = 4'b0100;
        wait_done("bnd_late", 32'h3f80_0000, cnt, hi);
        chk("bnd_late_err", Error, 1);
        chk("bnd_late_res", Result, 0);
        Req = '0;
        wait_idle("bnd_late");
        ack_lat = 5;

        // stray Ack in GAP and IDLE is ignored
        Req = 4'b0001;
        wait_done("stray", 32'h3f00_0000, cnt, hi);
        Req = '0;
        @(negedge Clock);
        ack_pulse = 1'b1;
        @(negedge Clock);
        ack_pulse = 1'b0;
        chk("stray_gap_done", Done, 0);
        wait_idle("stray");
        ack_pulse = 1'b1;
        @(negedge Clock);
        ack_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            chk("stray_idle_done", Done, 0);
            chk("stray_idle_busy", Busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
